// File: rtl/clock_domain_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : clock_domain_pkg                                        |
// | Purpose  : Shared state encoding, defaults and field helper for    |
// |            the clock-domain run-control block.                     |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package clock_domain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_WARM  = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  localparam int unsigned CNT_W_DEF      = 32;
  localparam int unsigned RST_CYC_DEF    = 1;
  localparam int unsigned EN_DLY_DEF     = 1;
  localparam int unsigned N_CH_DEF       = 2;
  localparam int unsigned DIV_W_DEF      = 8;
  localparam int unsigned AUTO_START_DEF = 1;

  // Channel fields are at most FIELD_MAX_W bits; the packed bus at most BUS_MAX_W.
  localparam int unsigned FIELD_MAX_W = 32;
  localparam int unsigned BUS_MAX_W   = 256;

  function automatic logic [FIELD_MAX_W-1:0] ch_field(
    input logic [BUS_MAX_W-1:0] bus,
    input int unsigned          ch,
    input int unsigned          w
  );
    logic [FIELD_MAX_W-1:0] mask;
    mask = (w >= FIELD_MAX_W) ? '1 : ((FIELD_MAX_W'(1) << w) - FIELD_MAX_W'(1));
    return FIELD_MAX_W'(bus >> (ch * w)) & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clock_domain_strobe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : clock_domain_strobe                                     |
// | Purpose  : One divided tick channel: captures divide/phase, clamps |
// |            phase to divide, counts down during RUN.                |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module clock_domain_strobe #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             capture_i,
  input  logic             load_i,
  input  logic             run_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [DIV_W-1:0] phs_i,
  output logic             stb_o
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] phs_q, phs_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             stb_q, stb_d;

  // cnt_q holds the countdown value for the following RUN cycle, so the
  // strobe can be registered while still firing on the cycle c_i==0.
  always_comb begin
    div_d = div_q;
    phs_d = phs_q;
    cnt_d = cnt_q;
    stb_d = 1'b0;
    if (capture_i) begin
      div_d = div_i;
      phs_d = (phs_i > div_i) ? div_i : phs_i;
    end
    if (load_i) begin
      stb_d = (phs_q == '0);
      cnt_d = (phs_q == '0) ? div_q : phs_q - DIV_W'(1);
    end else if (run_i) begin
      stb_d = (cnt_q == '0);
      cnt_d = (cnt_q == '0) ? div_q : cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q <= '0;
      phs_q <= '0;
      cnt_q <= '0;
      stb_q <= 1'b0;
    end else begin
      div_q <= div_d;
      phs_q <= phs_d;
      cnt_q <= cnt_d;
      stb_q <= stb_d;
    end
  end

  assign stb_o = stb_q;

endmodule
`default_nettype wire

// File: rtl/clock_domain_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : clock_domain_ctrl                                       |
// | Purpose  : Run control for one clock domain: local reset pulse,    |
// |            delayed enable, run-cycle counter and N_CH tick strobes.|
// |            Macro CLKDOM_CNT_SAT_EN: counter saturates, OVF active. |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module clock_domain_ctrl
  import clock_domain_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned RST_CYC    = RST_CYC_DEF,
  parameter int unsigned EN_DLY     = EN_DLY_DEF,
  parameter int unsigned N_CH       = N_CH_DEF,
  parameter int unsigned DIV_W      = DIV_W_DEF,
  parameter int unsigned AUTO_START = AUTO_START_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [N_CH*DIV_W-1:0] div_i,
  input  logic [N_CH*DIV_W-1:0] phs_i,
  output logic                  lrst_o,
  output logic                  en_o,
  output logic [CNT_W-1:0]      cnt_o,
  output logic [N_CH-1:0]       stb_o,
  output logic                  busy_o,
  output logic                  ovf_o
);

  localparam int unsigned TMR_MAX = (RST_CYC > EN_DLY) ? RST_CYC : EN_DLY;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1) + 1;
  localparam int unsigned RST_LD  = (RST_CYC > 0) ? RST_CYC - 1 : 0;
  localparam int unsigned WARM_LD = (EN_DLY > 0) ? EN_DLY - 1 : 0;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             first_q;
  logic             lrst_q, en_q, busy_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w_capture, w_load, w_run;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i || ((AUTO_START != 0) && first_q)) begin
          state_d = ST_RESET;
          tmr_d   = TMR_W'(RST_LD);
        end
      end
      ST_RESET: begin
        if (stop_i) begin
          state_d = ST_IDLE;
        end else if (tmr_q == '0) begin
          if (EN_DLY == 0) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_WARM;
            tmr_d   = TMR_W'(WARM_LD);
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_WARM: begin
        if (stop_i) begin
          state_d = ST_IDLE;
        end else if (tmr_q == '0) begin
          state_d = ST_RUN;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_RUN: begin
        if (stop_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign w_capture = (state_q == ST_IDLE) && (state_d == ST_RESET);
  assign w_load    = (state_q != ST_RUN) && (state_d == ST_RUN);
  assign w_run     = (state_q == ST_RUN) && (state_d == ST_RUN);

  always_comb begin
    cnt_d = cnt_q;
    if (w_load) begin
      cnt_d = '0;
    end else if (w_run) begin
`ifdef CLKDOM_CNT_SAT_EN
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
`else
      cnt_d = cnt_q + CNT_W'(1);
`endif
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      first_q <= 1'b1;
      lrst_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      first_q <= 1'b0;
      lrst_q  <= (state_d == ST_RESET);
      en_q    <= (state_d == ST_RUN);
      busy_q  <= (state_d != ST_IDLE);
      cnt_q   <= cnt_d;
    end
  end

`ifdef CLKDOM_CNT_SAT_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (w_load) begin
      ovf_d = 1'b0;
    end else if (w_run && (cnt_d == '1)) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ovf_o = ovf_q;
`else
  assign ovf_o = 1'b0;
`endif

  logic [BUS_MAX_W-1:0] w_div_bus, w_phs_bus;
  assign w_div_bus = BUS_MAX_W'(div_i);
  assign w_phs_bus = BUS_MAX_W'(phs_i);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [DIV_W-1:0] w_div, w_phs;
    assign w_div = DIV_W'(ch_field(w_div_bus, gi, DIV_W));
    assign w_phs = DIV_W'(ch_field(w_phs_bus, gi, DIV_W));

    clock_domain_strobe #(
      .DIV_W(DIV_W)
    ) u_strobe (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .capture_i(w_capture),
      .load_i   (w_load),
      .run_i    (w_run),
      .div_i    (w_div),
      .phs_i    (w_phs),
      .stb_o    (stb_o[gi])
    );
  end

  assign lrst_o = lrst_q;
  assign en_o   = en_q;
  assign busy_o = busy_q;
  assign cnt_o  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_domain_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_clock_domain_ctrl                                    |
// | Purpose  : Two differently parameterised instances driven together |
// |            and compared every cycle against a timeline model.      |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_clock_domain_ctrl;

`ifdef CLKDOM_CNT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, stop;
  logic [7:0] div, phs;

  logic       lrst_a, en_a, busy_a, ovf_a;
  logic [3:0] cnt_a;
  logic [1:0] stb_a;
  logic       lrst_b, en_b, busy_b, ovf_b;
  logic [7:0] cnt_b;
  logic [1:0] stb_b;

  always #5 clk = ~clk;

  clock_domain_ctrl #(
    .CNT_W(4), .RST_CYC(1), .EN_DLY(1), .N_CH(2), .DIV_W(4), .AUTO_START(1)
  ) u_dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
    .div_i(div), .phs_i(phs),
    .lrst_o(lrst_a), .en_o(en_a), .cnt_o(cnt_a), .stb_o(stb_a),
    .busy_o(busy_a), .ovf_o(ovf_a)
  );

  clock_domain_ctrl #(
    .CNT_W(8), .RST_CYC(3), .EN_DLY(0), .N_CH(2), .DIV_W(4), .AUTO_START(0)
  ) u_dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
    .div_i(div), .phs_i(phs),
    .lrst_o(lrst_b), .en_o(en_b), .cnt_o(cnt_b), .stb_o(stb_b),
    .busy_o(busy_b), .ovf_o(ovf_b)
  );

  // Per-instance configuration seen by the model.
  int R[2]    = '{1, 3};
  int E[2]    = '{1, 0};
  int MAXC[2] = '{15, 255};
  bit AUTO[2] = '{1'b1, 1'b0};

  // Model: an active run is described by the cycle START was sampled in.
  bit act[2]      = '{1'b0, 1'b0};
  int ts[2]       = '{0, 0};
  int held_cnt[2] = '{0, 0};
  bit held_ovf[2] = '{1'b0, 1'b0};
  bit first[2]    = '{1'b0, 1'b0};
  int cd[2][2];
  int cp[2][2];

  int cyc    = -1;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_expect(input int d, input int c,
                              output logic e_lrst, output logic e_en, output logic e_busy,
                              output int e_cnt, output logic [1:0] e_stb, output logic e_ovf);
    int k, n;
    e_lrst = 1'b0; e_en = 1'b0; e_busy = act[d];
    e_cnt  = held_cnt[d]; e_stb = 2'b00; e_ovf = held_ovf[d];
    if (act[d]) begin
      k = c - ts[d];
      if (k <= R[d]) begin
        e_lrst = 1'b1;
      end else if (k >= 1 + R[d] + E[d]) begin
        n    = k - 1 - R[d] - E[d];
        e_en = 1'b1;
        if (SAT) begin
          e_cnt = (n > MAXC[d]) ? MAXC[d] : n;
          e_ovf = (n >= MAXC[d]);
        end else begin
          e_cnt = n % (MAXC[d] + 1);
          e_ovf = 1'b0;
        end
        for (int i = 0; i < 2; i++)
          e_stb[i] = (n >= cp[d][i]) && (((n - cp[d][i]) % (cd[d][i] + 1)) == 0);
      end
    end
  endtask

  task automatic model_step(input int d, input int c);
    logic l, e, b, o;
    logic [1:0] s;
    int cn;
    if (rst) begin
      act[d] = 1'b0; held_cnt[d] = 0; held_ovf[d] = 1'b0; first[d] = 1'b1;
    end else if (!act[d]) begin
      if (start || (AUTO[d] && first[d])) begin
        act[d] = 1'b1;
        ts[d]  = c;
        for (int i = 0; i < 2; i++) begin
          cd[d][i] = int'(div[4*i +: 4]);
          cp[d][i] = int'(phs[4*i +: 4]);
          if (cp[d][i] > cd[d][i]) cp[d][i] = cd[d][i];
        end
      end
      first[d] = 1'b0;
    end else begin
      first[d] = 1'b0;
      if (stop) begin
        model_expect(d, c, l, e, b, cn, s, o);
        held_cnt[d] = cn;
        held_ovf[d] = o;
        act[d]      = 1'b0;
      end
    end
  endtask

  task automatic check_dut(input int d, input logic g_lrst, input logic g_en, input logic g_busy,
                           input logic [31:0] g_cnt, input logic [1:0] g_stb, input logic g_ovf);
    logic e_lrst, e_en, e_busy, e_ovf;
    logic [1:0] e_stb;
    int e_cnt;
    model_expect(d, cyc, e_lrst, e_en, e_busy, e_cnt, e_stb, e_ovf);
    chk($sformatf("d%0d_lrst", d), 32'(g_lrst), 32'(e_lrst));
    chk($sformatf("d%0d_en", d),   32'(g_en),   32'(e_en));
    chk($sformatf("d%0d_busy", d), 32'(g_busy), 32'(e_busy));
    chk($sformatf("d%0d_cnt", d),  g_cnt,       32'(e_cnt));
    chk($sformatf("d%0d_stb", d),  32'(g_stb),  32'(e_stb));
    chk($sformatf("d%0d_ovf", d),  32'(g_ovf),  32'(e_ovf));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, cyc);
    model_step(1, cyc);
    cyc++;
    #1;
    check_dut(0, lrst_a, en_a, busy_a, 32'(cnt_a), stb_a, ovf_a);
    check_dut(1, lrst_b, en_b, busy_b, 32'(cnt_b), stb_b, ovf_b);
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    div = 8'h03; phs = 8'h01;           // ch0: DIV=3 PHS=1, ch1: DIV=0 PHS=0
    tick(); tick();
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_cnt_b",  32'(cnt_b),  32'd0);
    rst = 1'b0;

    tick();
    chk("auto_lrst_c2", 32'(lrst_a), 32'd1);
    run_to(4);
    chk("auto_en_c4",  32'(en_a),  32'd1);
    chk("auto_cnt_c4", 32'(cnt_a), 32'd0);

    run_to(10);
    start = 1'b1; tick(); start = 1'b0;
    chk("b_lrst_c11", 32'(lrst_b), 32'd1);
    chk("b_busy_c11", 32'(busy_b), 32'd1);
    run_to(13);
    chk("b_lrst_c13", 32'(lrst_b), 32'd1);
    tick();
    chk("b_en_c14",  32'(en_b),  32'd1);
    chk("b_cnt_c14", 32'(cnt_b), 32'd0);
    chk("b_stb_c14", 32'(stb_b), 32'd2);

    run_to(20);
    chk("a_cnt_wrap", 32'(cnt_a), SAT ? 32'd15 : 32'd0);
    chk("a_ovf_wrap", 32'(ovf_a), SAT ? 32'd1 : 32'd0);

    tick();
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_en",   32'(en_b),  32'd0);
    chk("stop_stb",  32'(stb_b), 32'd0);
    chk("stop_cnt7", 32'(cnt_b), 32'd7);

    div = 8'h03; phs = 8'h09;           // ch0 PHS=9 clamps to DIV=3
    start = 1'b1; tick(); start = 1'b0;
    div = 8'hff; phs = 8'hff;           // changes after capture must be ignored
    run_to(26);
    chk("restart_cnt0", 32'(cnt_b), 32'd0);
    run_to(28);
    chk("clamp_nostb", 32'(stb_b[0]), 32'd0);
    tick();
    chk("clamp_stb", 32'(stb_b[0]), 32'd1);

    run_to(32);
    stop = 1'b1; tick(); stop = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_rst_lrst", 32'(lrst_b), 32'd0);
    chk("stop_rst_busy", 32'(busy_b), 32'd0);

    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("startstop_lrst", 32'(lrst_b), 32'd1);

    run_to(45);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_en_b",  32'(en_b),  32'd0);
    chk("midrst_cnt_b", 32'(cnt_b), 32'd0);
    chk("midrst_busy_a", 32'(busy_a), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 255) == 0);
      start = ($urandom_range(0, 5) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      div   = 8'($urandom);
      phs   = 8'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
